// File: rtl/output_queue_if.sv
// Sample stream handshake between the IFFT and the output queue.
// master drives data/valid/last; slave returns ready.
interface output_queue_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  input_valid;
  logic                  input_last;
  logic                  input_ready;

  modport master (
    output data_in,
    output input_valid,
    output input_last,
    input  input_ready
  );

  modport slave (
    input  data_in,
    input  input_valid,
    input  input_last,
    output input_ready
  );
endinterface

// File: rtl/output_queue.sv
// Output queue: buffers IFFT samples, releases one per audio tick as PWM.
// Ports: clock, reset (sync, active-high), in_if (slave: data_in,
// input_valid, input_last, input_ready), aud_pwm, aud_sd, underflow, level.
// Option: OUTPUT_QUEUE_HOLD_ON_UNDERFLOW_EN keeps playing through underflow.
module output_queue #(
  parameter int DATA_WIDTH      = 16,
  parameter int PWM_BITS        = 8,
  parameter int DEPTH           = 2048,
  parameter int CLKS_PER_SAMPLE = 2268
) (
  input  logic                   clock,
  input  logic                   reset,
  output_queue_if.slave          in_if,
  output logic                   aud_pwm,
  output logic                   aud_sd,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_SAMPLE);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_SAMPLE - 1);

  typedef enum logic {
    PREFILL,
    PLAY
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_q, level_d;
  logic                  ready_q;
  logic [CW-1:0]         smp_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt, duty_q, duty_d;
  logic [DATA_WIDTH-1:0] sample_q;
  logic                  tick, push, pop, uf_hit;
  logic                  unused_lsb;

  assign tick  = (smp_cnt == CMAX);
  assign level = level_q;
  assign aud_sd = (state_q == PLAY);
  assign in_if.input_ready = ready_q;

  // Offset binary: flip the sign bit, keep the top PWM_BITS.
  assign duty_d = {~sample_q[DATA_WIDTH-1],
                   sample_q[DATA_WIDTH-2 -: PWM_BITS-1]};
  assign unused_lsb = ^sample_q[DATA_WIDTH-PWM_BITS-1:0];

  always_comb begin
    state_d = state_q;
    push    = in_if.input_valid & ready_q;
    pop     = 1'b0;
    uf_hit  = 1'b0;
    unique case (state_q)
      PREFILL: begin
        if ((push & in_if.input_last) | (level_q == FULL))
          state_d = PLAY;
      end
      PLAY: begin
        if (tick) begin
          if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            uf_hit = 1'b1;
`ifdef OUTPUT_QUEUE_HOLD_ON_UNDERFLOW_EN
            state_d = PLAY;
`else
            state_d = PREFILL;
`endif
          end
        end
      end
      default: state_d = PREFILL;
    endcase
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Sample storage is left unreset; pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= in_if.data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= PREFILL;
      level_q   <= '0;
      ready_q   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      smp_cnt   <= '0;
      pwm_cnt   <= '0;
      sample_q  <= '0;
      duty_q    <= '0;
      aud_pwm   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      ready_q   <= (level_d < FULL);
      underflow <= uf_hit;
      smp_cnt   <= tick ? '0 : smp_cnt + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        sample_q <= mem[rd_ptr];
      end else if (state_d == PREFILL) begin
        sample_q <= '0;
      end
      // New duty only at the period boundary so no PWM pulse is torn.
      if (pwm_cnt == '1)
        duty_q <= duty_d;
      aud_pwm <= (pwm_cnt < duty_q);
    end
  end

endmodule

// File: tb/tb_output_queue.sv
// Directed bench for output_queue: reset, duty table, underflow,
// full FIFO and mid-play reset.
module tb_output_queue;

  localparam int DW    = 16;
  localparam int DEPTH = 2048;
  localparam int CPS   = 300;
  localparam int PB    = 8;

`ifdef OUTPUT_QUEUE_HOLD_ON_UNDERFLOW_EN
  localparam logic EXP_SD_UF = 1'b1;
`else
  localparam logic EXP_SD_UF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        aud_pwm, aud_sd, underflow;
  logic [11:0] level;

  int checks = 0;
  int errors = 0;

  output_queue_if #(.DATA_WIDTH(DW)) bus ();

  output_queue #(
    .DATA_WIDTH(DW),
    .PWM_BITS(PB),
    .DEPTH(DEPTH),
    .CLKS_PER_SAMPLE(CPS)
  ) dut (
    .clock(clk),
    .reset(reset),
    .in_if(bus),
    .aud_pwm(aud_pwm),
    .aud_sd(aud_sd),
    .underflow(underflow),
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] smp;
    int          high;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    bus.input_valid = 1'b0;
    bus.input_last  = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    int w;
    w = 0;
    while (!bus.input_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("push_ready", bus.input_ready, 1);
    bus.data_in     = d;
    bus.input_last  = l;
    bus.input_valid = 1'b1;
    @(negedge clk);
    bus.input_valid = 1'b0;
    bus.input_last  = 1'b0;
  endtask

  initial begin
    int hi, n, dec, uf, seen, t1, t2;
    logic [11:0] prev;

    vt[0] = '{16'h4000, 192};
    vt[1] = '{16'h8000, 0};
    vt[2] = '{16'h0000, 128};
    vt[3] = '{16'h7FFF, 255};
    vt[4] = '{16'hC000, 64};
    vt[5] = '{16'hFF00, 127};

    bus.data_in     = '0;
    bus.input_valid = 1'b0;
    bus.input_last  = 1'b0;

    // Reset state and idle.
    repeat (3) @(negedge clk);
    check("rst_ready", bus.input_ready, 0);
    check("rst_level", level, 0);
    check("rst_pwm", aud_pwm, 0);
    check("rst_sd", aud_sd, 0);
    check("rst_uf", underflow, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.input_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_sd", aud_sd, 0);
      check("idle_pwm", aud_pwm, 0);
      check("idle_level", level, 0);
    end

    // Duty table: steady sample, count highs over one PWM period.
    for (int v = 0; v < 6; v++) begin
      reset_dut();
      for (int k = 0; k < 4; k++)
        push(vt[v].smp, k == 3);
      check("vec_sd", aud_sd, 1);
      repeat (700) @(negedge clk);
      hi = 0;
      for (int k = 0; k < 256; k++) begin
        @(negedge clk);
        hi += int'(aud_pwm);
      end
      check($sformatf("duty_%04h", vt[v].smp), hi, vt[v].high);
    end

    // 16-sample frame, then starve until underflow.
    reset_dut();
    for (int k = 0; k < 16; k++)
      push(16'h1000 + 16'(k), k == 15);
    check("frame_sd", aud_sd, 1);
    check("frame_level", level, 16);
    dec = 0; uf = 0; seen = -1; t1 = 0; t2 = 0;
    prev = level;
    for (int c = 0; c < 5600; c++) begin
      @(negedge clk);
      if (level < prev) begin
        dec++;
        if (dec == 1) t1 = c;
        if (dec == 2) t2 = c;
      end
      prev = level;
      if (underflow) begin
        uf++;
        if (seen < 0) begin
          seen = c;
          check("uf_sd", aud_sd, EXP_SD_UF);
          check("uf_pops", dec, 16);
          check("uf_level", level, 0);
        end
      end
      if (seen >= 0 && c >= seen + 5) break;
    end
    check("uf_seen", seen >= 0, 1);
    check("uf_once", uf, 1);
    check("dec_gap", t2 - t1, CPS);
    check("uf_sd_after", aud_sd, EXP_SD_UF);

    // Fill to DEPTH without input_last.
    reset_dut();
    bus.data_in     = 16'h1234;
    bus.input_last  = 1'b0;
    bus.input_valid = 1'b1;
    n = 0;
    while (level != 12'(DEPTH) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("full_level", level, DEPTH);
    check("full_ready", bus.input_ready, 0);
    bus.input_valid = 1'b0;
    @(negedge clk);
    check("full_play", aud_sd, 1);
    n = 0;
    while (level != 12'(DEPTH - 1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("full_pop", level, DEPTH - 1);
    repeat (299) @(negedge clk);
    check("pre_pp_level", level, DEPTH - 1);
    check("pre_pp_ready", bus.input_ready, 1);
    bus.input_valid = 1'b1;
    @(negedge clk);
    bus.input_valid = 1'b0;
    check("push_pop_level", level, DEPTH - 1);

    // Reset in the middle of PLAY.
    reset_dut();
    for (int k = 0; k < 500; k++)
      push(16'h7FFF, k == 499);
    check("mid_level", level, 500);
    check("mid_sd", aud_sd, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_level", level, 0);
    check("mid_rst_sd", aud_sd, 0);
    check("mid_rst_pwm", aud_pwm, 0);
    check("mid_rst_ready", bus.input_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rel_ready", bus.input_ready, 1);
    check("mid_rel_sd", aud_sd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
